register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
// - Parametrised multi-read-port register file for the RISC-V core.
// - Successor to the fixed 32x32, 2-read-port file. Adds:
//   - configurable width, depth and read-port count
//   - optional hardwired-zero x0
//   - write-to-read bypass
//   - asynchronous reset
//   - sequenced bulk-clear engine
// - Sits between decode (rd_addr) and ALU operand muxes; writeback drives the write port.
// PARAMETERS
// - N           32  data width in bits
// - NUM_REGS    32  number of architectural registers (>=2; power of 2 not required)
// - NUM_RD      2   number of independent combinational read ports (1..4)
// - ZERO_REG    1   1: register 0 reads 0, writes to it are dropped
// - BYPASS      1   1: same-cycle accepted write is forwarded to matching read ports
// - RESET_VALUE 0   value loaded into every register on rst and by bulk clear
// PORTS   (A = $clog2(NUM_REGS))
// - clk        in   1             rising-edge clock
// - rst        in   1             asynchronous reset, active-high
// - wr_ena     in   1             write request
// - wr_addr    in   A             write register index
// - wr_data    in   N             write data
// - wr_ready   out  1             1 when a write can be accepted (low while clearing)
// - rd_addr    in   NUM_RD*A      packed read indices, port k = [k*A +: A]
// - rd_data    out  NUM_RD*N      packed read data, port k = [k*N +: N]
// - clr_req    in   1             bulk-clear request (level sampled in IDLE)
// - clr_busy   out  1             high while the clear sequence runs
// - clr_done   out  1             one-cycle pulse after the last register is cleared
// BEHAVIOUR
// - Reset (async assert, sync-safe deassert):
//   - all registers = RESET_VALUE; FSM = IDLE; clr_idx = 0
//   - clr_busy = 0, clr_done = 0, wr_ready = 1
// - Write accept:
//   - condition: wr_acc = wr_ena & wr_ready & (wr_addr < NUM_REGS) & !(ZERO_REG & wr_addr==0)
//   - register updates at the next posedge; write latency is 1 cycle.
// - Read: purely combinational, 0-cycle latency.
//   - rd_addr >= NUM_REGS -> 0
//   - ZERO_REG & rd_addr==0 -> 0
//   - BYPASS & wr_acc & rd_addr==wr_addr -> wr_data (new value, write-first)
//   - otherwise -> stored contents
// - Ports are independent: all NUM_RD ports may hit the same index, and all may bypass in the same cycle.
// - FSM states: IDLE, CLEAR, DONE.
//   - IDLE -> CLEAR when clr_req=1; clr_idx <= 0.
//   - CLEAR:
//     - each cycle reg[clr_idx] <= RESET_VALUE and clr_idx increments
//     - when clr_idx==NUM_REGS-1 -> DONE
//     - clr_busy=1, wr_ready=0; wr_ena is dropped (no bypass)
//   - DONE: clr_done=1 for exactly one cycle, clr_busy=0, wr_ready=1 -> IDLE.
//   - Total: clr_busy high for NUM_REGS cycles; clr_done follows on the next cycle.
// - Boundary cases:
//   - clr_req and wr_ena in the same IDLE cycle: the write is accepted, then the clear erases it.
//   - clr_req held high: a new clear starts each time the FSM returns to IDLE.
//   - clr_req while in CLEAR/DONE: ignored.
//   - Reads during CLEAR: return current contents (already-cleared entries read RESET_VALUE).
//   - rst mid-clear: immediately IDLE, all registers = RESET_VALUE, no clr_done pulse.
//   - wr_ena with X address or data while wr_ready=0: no state change.
// STRUCTURE
// - Package rf_pkg holds:
//   - typedef enum logic [1:0] {RF_IDLE, RF_CLEAR, RF_DONE} rf_state_t
//   - localparams RV_XLEN=32 and RV_NREGS=32 (the defaults)
// - Storage is generate-instantiated flip-flops, one per register, via the existing `register` sub-module
//   - `register` gains async rst and ena; d is selected between wr_data and RESET_VALUE.
// - No inferred RAM arrays; read muxing is one generate loop per port.
// TESTING
// - rst=1, then read all 32 indices on both ports -> all 0; wr_ready=1, clr_busy=0.
// - Write x5=32'hDEADBEEF; next cycle rd_addr0=5 -> 32'hDEADBEEF. Write x0=32'h1234 -> reads of x0 stay 0.
// - wr_ena, wr_addr=7, wr_data=32'hA5A5A5A5, with rd_addr0=rd_addr1=7 in the same cycle -> both rd_data = 32'hA5A5A5A5 (BYPASS=1).
//   - With BYPASS=0 -> both read the old value.
// - Fill x1..x31 with i*3, pulse clr_req:
//   - clr_busy high for exactly 32 cycles, clr_done on cycle 33
//   - writes during busy are ignored; afterwards all reads = 0
// - Start a clear, assert rst at clr_idx=10 -> clr_busy=0 next sample, no clr_done, all registers 0.
// - Param sweep N=16/NUM_REGS=8/NUM_RD=3/ZERO_REG=0:
//   - write x0=16'hBEEF -> all 3 ports read 16'hBEEF
//   - clear takes 8 cycles

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and default sizes for the multi-port register file.
package rf_pkg;

  typedef enum logic [1:0] {RF_IDLE, RF_CLEAR, RF_DONE} rf_state_t;

  localparam int RV_XLEN  = 32;
  localparam int RV_NREGS = 32;

endpackage

// File: rtl/register.sv
// One architectural register: async reset to RESET_VALUE, load on ena.
module register
  import rf_pkg::*;
#(
  parameter int            N           = RV_XLEN,
  parameter logic [N-1:0]  RESET_VALUE = '0
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= RESET_VALUE;
    else if (ena) q <= d;
  end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-read-port register file with optional x0, write bypass
// and a sequenced bulk-clear engine that walks one register per cycle.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int           N           = RV_XLEN,
  parameter int           NUM_REGS    = RV_NREGS,
  parameter int           NUM_RD      = 2,
  parameter bit           ZERO_REG    = 1'b1,
  parameter bit           BYPASS      = 1'b1,
  parameter logic [N-1:0] RESET_VALUE = '0,
  localparam int          A           = $clog2(NUM_REGS)
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_ena,
  input  logic [A-1:0]        wr_addr,
  input  logic [N-1:0]        wr_data,
  output logic                wr_ready,
  input  logic [NUM_RD*A-1:0] rd_addr,
  output logic [NUM_RD*N-1:0] rd_data,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  localparam logic [A:0]   REG_COUNT = (A+1)'(NUM_REGS);
  localparam logic [A-1:0] LAST_IDX  = A'(NUM_REGS - 1);

  rf_state_t    state_q, state_d;
  logic [A-1:0] clr_idx_q, clr_idx_d;
  logic         wr_acc;
  logic [N-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RF_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_ready  = 1'b1;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    unique case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d   = RF_CLEAR;
          clr_idx_d = '0;
        end
      end
      RF_CLEAR: begin
        wr_ready  = 1'b0;
        clr_busy  = 1'b1;
        clr_idx_d = clr_idx_q + A'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d   = RF_DONE;
          clr_idx_d = '0;
        end
      end
      RF_DONE: begin
        clr_done = 1'b1;
        state_d  = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  // Writes are dropped while clearing, out of range, or aimed at a hardwired x0.
  assign wr_acc = wr_ena && wr_ready && ({1'b0, wr_addr} < REG_COUNT)
                  && !(ZERO_REG && (wr_addr == '0));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic hit_wr, hit_clr;
    assign hit_wr  = wr_acc && (wr_addr == A'(i));
    assign hit_clr = clr_busy && (clr_idx_q == A'(i));
    register #(.N(N), .RESET_VALUE(RESET_VALUE)) u_reg (
      .clk (clk),
      .rst (rst),
      .ena (hit_wr || hit_clr),
      .d   (hit_clr ? RESET_VALUE : wr_data),
      .q   (regs_q[i])
    );
  end

  // Each port is an independent mux; out-of-range indices match no entry and read 0.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [A-1:0] addr;
    logic [N-1:0] val;
    assign addr = rd_addr[k*A +: A];
    always_comb begin
      val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr == A'(i)) val = regs_q[i];
      end
      if (ZERO_REG && (addr == '0)) val = '0;
      if (BYPASS && wr_acc && (addr == wr_addr)) val = wr_data;
    end
    assign rd_data[k*N +: N] = val;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised and directed checks of register_file_mp against an array-based model.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default configuration (dut) and the same with bypass disabled (dut_nb)
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic        clr_req;
  logic        wr_ready, clr_busy, clr_done;
  logic [63:0] rd_data;
  logic        wr_ready_nb, clr_busy_nb, clr_done_nb;
  logic [63:0] rd_data_nb;

  // N=16, NUM_REGS=8, NUM_RD=3, ZERO_REG=0
  logic        s_wr_ena;
  logic [2:0]  s_wr_addr;
  logic [15:0] s_wr_data;
  logic [8:0]  s_rd_addr;
  logic        s_clr_req;
  logic        s_wr_ready, s_clr_busy, s_clr_done;
  logic [47:0] s_rd_data;

  register_file_mp dut (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_data(rd_data), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  register_file_mp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready_nb), .rd_addr(rd_addr), .rd_data(rd_data_nb), .clr_req(clr_req),
    .clr_busy(clr_busy_nb), .clr_done(clr_done_nb)
  );

  register_file_mp #(.N(16), .NUM_REGS(8), .NUM_RD(3), .ZERO_REG(1'b0)) dut_s (
    .clk(clk), .rst(rst), .wr_ena(s_wr_ena), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .wr_ready(s_wr_ready), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .clr_req(s_clr_req),
    .clr_busy(s_clr_busy), .clr_done(s_clr_done)
  );

  // reference model: register contents plus clear progress
  logic [31:0] mem [32];
  int          clr_left, clr_pos;
  bit          done_p;
  logic [15:0] smem [8];
  int          s_left, s_pos;
  bit          s_done_p;

  int n_asserts = 0;
  int n_fail    = 0;
  int busy_cnt, done_at, done_cnt;

  function automatic bit acc_main();
    return (wr_ena === 1'b1) && (clr_left == 0) && (wr_addr != 5'd0);
  endfunction

  function automatic bit acc_s();
    return (s_wr_ena === 1'b1) && (s_left == 0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return '0;
    if (byp && acc_main() && (a == wr_addr)) return wr_data;
    return mem[a];
  endfunction

  function automatic logic [15:0] exp_s_rd(input logic [2:0] a);
    if (acc_s() && (a == s_wr_addr)) return s_wr_data;
    return smem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) smem[i] = '0;
    clr_left = 0; clr_pos = 0; done_p = 1'b0;
    s_left = 0; s_pos = 0; s_done_p = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s/ready", tag), 64'(wr_ready), 64'(clr_left == 0));
    check($sformatf("%s/busy", tag), 64'(clr_busy), 64'(clr_left > 0));
    check($sformatf("%s/done", tag), 64'(clr_done), 64'(done_p));
    check($sformatf("%s/ready_nb", tag), 64'(wr_ready_nb), 64'(clr_left == 0));
    check($sformatf("%s/busy_nb", tag), 64'(clr_busy_nb), 64'(clr_left > 0));
    check($sformatf("%s/done_nb", tag), 64'(clr_done_nb), 64'(done_p));
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s/rd%0d", tag, k), 64'(rd_data[k*32 +: 32]),
            64'(exp_rd(rd_addr[k*5 +: 5], 1'b1)));
      check($sformatf("%s/rd%0d_nb", tag, k), 64'(rd_data_nb[k*32 +: 32]),
            64'(exp_rd(rd_addr[k*5 +: 5], 1'b0)));
    end
    check($sformatf("%s/s_ready", tag), 64'(s_wr_ready), 64'(s_left == 0));
    check($sformatf("%s/s_busy", tag), 64'(s_clr_busy), 64'(s_left > 0));
    check($sformatf("%s/s_done", tag), 64'(s_clr_done), 64'(s_done_p));
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s/s_rd%0d", tag, k), 64'(s_rd_data[k*16 +: 16]),
            64'(exp_s_rd(s_rd_addr[k*3 +: 3])));
    end
  endtask

  // One clock: advance the model on the rising edge, return on the falling edge.
  task automatic tick();
    bit a, sa;
    a  = acc_main();
    sa = acc_s();
    @(posedge clk);
    if (a) mem[wr_addr] = wr_data;
    if (done_p) done_p = 1'b0;
    else if (clr_left > 0) begin
      mem[clr_pos] = '0; clr_pos++; clr_left--;
      if (clr_left == 0) done_p = 1'b1;
    end else if (clr_req) begin
      clr_left = 32; clr_pos = 0;
    end
    if (sa) smem[s_wr_addr] = s_wr_data;
    if (s_done_p) s_done_p = 1'b0;
    else if (s_left > 0) begin
      smem[s_pos] = '0; s_pos++; s_left--;
      if (s_left == 0) s_done_p = 1'b1;
    end else if (s_clr_req) begin
      s_left = 8; s_pos = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    wr_ena = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; clr_req = 1'b0;
    s_wr_ena = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rd_addr = '0; s_clr_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_all("reset");
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - i), 5'(i)};
      #1;
      check($sformatf("reset_rd0_x%0d", i), 64'(rd_data[31:0]), 64'd0);
      check($sformatf("reset_rd1_x%0d", 31 - i), 64'(rd_data[63:32]), 64'd0);
    end
    @(negedge clk);

    // plain write then read
    wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    #1 check_all("wr_x5");
    tick();
    wr_ena = 1'b0; rd_addr = {5'd0, 5'd5};
    #1 check("x5_read", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check_all("x5");

    // writes to x0 are dropped
    wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr = '0;
    #1 check("x0_same_cycle", 64'(rd_data[31:0]), 64'd0);
    tick();
    wr_ena = 1'b0;
    #1 check("x0_after", 64'(rd_data[63:32]), 64'd0);

    // bypass vs no bypass on both ports
    wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'h11112222;
    tick();
    wr_data = 32'hA5A5A5A5; rd_addr = {5'd7, 5'd7};
    #1 check("byp_rd0", 64'(rd_data[31:0]), 64'hA5A5A5A5);
    check("byp_rd1", 64'(rd_data[63:32]), 64'hA5A5A5A5);
    check("nobyp_rd0", 64'(rd_data_nb[31:0]), 64'h11112222);
    check("nobyp_rd1", 64'(rd_data_nb[63:32]), 64'h11112222);
    check_all("bypass");
    tick();
    wr_ena = 1'b0;
    #1 check("nobyp_after", 64'(rd_data_nb[31:0]), 64'hA5A5A5A5);

    // random traffic
    for (int c = 0; c < 60; c++) begin
      wr_ena  = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      rd_addr = 10'($urandom);
      if (c % 4 == 0) rd_addr = {wr_addr, wr_addr};
      #1 check_all("rand");
      tick();
    end

    // fill x1..x31 with i*3, then clear with a same-cycle write
    for (int i = 1; i < 32; i++) begin
      wr_ena = 1'b1; wr_addr = 5'(i); wr_data = 32'(i * 3);
      tick();
    end
    wr_addr = 5'd9; wr_data = 32'hFFFF0000; clr_req = 1'b1; rd_addr = {5'd9, 5'd4};
    #1 check("clr_start_byp", 64'(rd_data[63:32]), 64'hFFFF0000);
    check("fill_x4", 64'(rd_data[31:0]), 64'd12);
    check_all("clr_start");
    tick();
    clr_req = 1'b0;
    busy_cnt = 0; done_at = 0;
    for (int c = 1; c <= 36; c++) begin
      wr_ena = (clr_left > 0);
      if (c % 3 == 0) begin
        wr_addr = 'x; wr_data = 'x;
      end else begin
        wr_addr = 5'($urandom); wr_data = $urandom;
      end
      rd_addr = 10'($urandom);
      #1 check_all("clearing");
      if (clr_busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1 && done_at == 0) done_at = c;
      tick();
    end
    check("clr_busy_cycles", 64'(busy_cnt), 64'd32);
    check("clr_done_cycle", 64'(done_at), 64'd33);
    wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(i), 5'(i)};
      #1 check($sformatf("cleared_x%0d", i), 64'(rd_data[31:0]), 64'd0);
    end
    @(negedge clk);

    // clr_req held high restarts the clear after each return to idle
    clr_req = 1'b1; done_cnt = 0;
    for (int c = 0; c < 68; c++) begin
      rd_addr = 10'($urandom);
      #1 check_all("held");
      if (clr_done === 1'b1) done_cnt++;
      tick();
    end
    check("held_done_pulses", 64'(done_cnt), 64'd2);
    clr_req = 1'b0;
    repeat (4) begin
      #1 check_all("held_end");
      tick();
    end

    // reset in the middle of a clear
    wr_ena = 1'b1; wr_addr = 5'd20; wr_data = 32'h0BADF00D;
    tick();
    wr_ena = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) begin
      #1 check_all("pre_rst");
      tick();
    end
    rd_addr = {5'd20, 5'd3};
    #1 check("x20_before_rst", 64'(rd_data[63:32]), 64'h0BADF00D);
    rst = 1'b1;
    model_reset();
    #1 check("rst_busy", 64'(clr_busy), 64'd0);
    check("rst_x20", 64'(rd_data[63:32]), 64'd0);
    check_all("rst_mid");
    tick();
    rst = 1'b0;
    for (int c = 0; c < 36; c++) begin
      rd_addr = 10'($urandom);
      #1 check_all("post_rst");
      tick();
    end

    // narrow configuration without hardwired x0
    s_wr_ena = 1'b1; s_wr_addr = 3'd0; s_wr_data = 16'hBEEF;
    #1 check_all("s_wr_x0");
    tick();
    s_wr_ena = 1'b0; s_rd_addr = '0;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("s_x0_port%0d", k), 64'(s_rd_data[k*16 +: 16]), 64'hBEEF);
    for (int c = 0; c < 30; c++) begin
      s_wr_ena  = 1'($urandom_range(0, 1));
      s_wr_addr = 3'($urandom);
      s_wr_data = 16'($urandom);
      s_rd_addr = 9'($urandom);
      if (c % 3 == 0) s_rd_addr = {s_wr_addr, s_wr_addr, s_wr_addr};
      #1 check_all("s_rand");
      tick();
    end
    s_wr_ena = 1'b0; s_clr_req = 1'b1;
    #1 check_all("s_clr_start");
    tick();
    s_clr_req = 1'b0;
    busy_cnt = 0; done_at = 0;
    for (int c = 1; c <= 12; c++) begin
      s_wr_ena  = 1'($urandom_range(0, 1));
      s_wr_addr = 3'($urandom);
      s_wr_data = 16'($urandom);
      s_rd_addr = 9'($urandom);
      #1 check_all("s_clearing");
      if (s_clr_busy === 1'b1) busy_cnt++;
      if (s_clr_done === 1'b1 && done_at == 0) done_at = c;
      tick();
    end
    check("s_clr_busy_cycles", 64'(busy_cnt), 64'd8);
    check("s_clr_done_cycle", 64'(done_at), 64'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
